// File: rtl/regfile_pkg.sv
// Shared types for the register-file write path: address/data widths and the
// writeback entry carried through the secondary FIFO.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     data_t;

    typedef struct packed {
        reg_addr_t addr;
        data_t     data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_PRI,
        GRANT_SEC
    } grant_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t r);
        logic [NUM_REGS-1:0] m;
        m    = '0;
        m[r] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two result sources, the arbiter and decode.
interface regfile_wb_arbiter_if #(parameter int DEPTH = 4);
    import regfile_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                pri_valid;
    reg_addr_t           pri_reg;
    data_t               pri_data;
    logic                sec_valid;
    logic                sec_ready;
    reg_addr_t           sec_reg;
    data_t               sec_data;
    logic                pri_stall;
    logic                ctrl_writeEnable;
    reg_addr_t           ctrl_writeReg;
    data_t               data_writeReg;
    logic [NUM_REGS-1:0] pending_mask;
    logic [CNT_W-1:0]    fifo_count;

    modport master (
        output pri_valid, pri_reg, pri_data, sec_valid, sec_reg, sec_data,
        input  sec_ready, pri_stall, ctrl_writeEnable, ctrl_writeReg,
               data_writeReg, pending_mask, fifo_count
    );

    modport slave (
        input  pri_valid, pri_reg, pri_data, sec_valid, sec_reg, sec_data,
        output sec_ready, pri_stall, ctrl_writeEnable, ctrl_writeReg,
               data_writeReg, pending_mask, fifo_count
    );

endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of writeback entries; exposes every slot and its valid bit
// so the owner can build a pending-register mask.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                   clock,
    input  logic                   ctrl_reset_n,
    input  logic                   push_i,
    input  wb_entry_t              push_entry_i,
    input  logic                   pop_i,
    output wb_entry_t              head_o,
    output logic [CNT_W-1:0]       count_o,
    output logic                   full_o,
    output logic                   empty_o,
    output wb_entry_t [DEPTH-1:0]  entries_o,
    output logic [DEPTH-1:0]       valid_o
);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // NOTE: storage has no reset; an entry is only observable once the count covers it.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_entry_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
            else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
        end
    end

    always_comb begin
        logic [PTR_W-1:0] offset;
        for (int i = 0; i < DEPTH; i++) begin
            offset       = PTR_W'(i) - rd_ptr_q;
            entries_o[i] = mem_q[i];
            valid_o[i]   = ({1'b0, offset} < count_q);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges primary and buffered multdiv writebacks onto the single regfile
// write port, with a starvation guard and a pending-register mask.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clock,
    input  logic                 ctrl_reset_n,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    wb_entry_t             fifo_head;
    wb_entry_t [DEPTH-1:0] fifo_entries;
    logic [DEPTH-1:0]      fifo_valid;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full, fifo_empty;
    logic                  pri_ok, push, pop;
    grant_e                grant;

    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic                  pri_stall_q, pri_stall_d;
    logic                  we_q, we_d;
    reg_addr_t             wreg_q, wreg_d;
    data_t                 wdata_q, wdata_d;
    logic [NUM_REGS-1:0]   mask;

    assign pri_ok = bus.pri_valid && (bus.pri_reg != '0);
    assign push   = bus.sec_valid && !fifo_full && (bus.sec_reg != '0);
    assign pop    = (grant == GRANT_SEC);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .push_i       (push),
        .push_entry_i ('{addr: bus.sec_reg, data: bus.sec_data}),
        .pop_i        (pop),
        .head_o       (fifo_head),
        .count_o      (fifo_count),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .entries_o    (fifo_entries),
        .valid_o      (fifo_valid)
    );

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        grant = GRANT_NONE;
        if (pri_stall_q) begin
            if (!fifo_empty) grant = GRANT_SEC;
        end else if (pri_ok) begin
            grant = GRANT_PRI;
        end else if (!fifo_empty) begin
            grant = GRANT_SEC;
        end
    end

    // The head's losses are counted only while it waits behind the primary.
    always_comb begin
        starve_d    = starve_q;
        pri_stall_d = 1'b0;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (grant == GRANT_PRI) begin
            if (starve_q == STARVE_W'(STARVE_LIMIT - 1)) begin
                starve_d    = '0;
                pri_stall_d = 1'b1;
            end else begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_comb begin
        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        unique case (grant)
            GRANT_PRI: begin
                we_d    = 1'b1;
                wreg_d  = bus.pri_reg;
                wdata_d = bus.pri_data;
            end
            GRANT_SEC: begin
                we_d    = 1'b1;
                wreg_d  = fifo_head.addr;
                wdata_d = fifo_head.data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            starve_q    <= '0;
            pri_stall_q <= 1'b0;
            we_q        <= 1'b0;
            wreg_q      <= '0;
            wdata_q     <= '0;
        end else begin
            starve_q    <= starve_d;
            pri_stall_q <= pri_stall_d;
            we_q        <= we_d;
            wreg_q      <= wreg_d;
            wdata_q     <= wdata_d;
        end
    end

    // NOTE: blocking assignments here build the OR-reduction within one evaluation.
    always_comb begin
        mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i]) mask = mask | reg_onehot(fifo_entries[i].addr);
        end
        if (we_q) mask = mask | reg_onehot(wreg_q);
        mask[0] = 1'b0;
    end

    assign bus.sec_ready        = !fifo_full;
    assign bus.pri_stall        = pri_stall_q;
    assign bus.ctrl_writeEnable = we_q;
    assign bus.ctrl_writeReg    = wreg_q;
    assign bus.data_writeReg    = wdata_q;
    assign bus.pending_mask     = mask;
    assign bus.fifo_count       = fifo_count;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a vector table for single-cycle
// behaviour plus sequences for fill, starvation and mid-stream reset.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int DEPTH = 4;

    logic clock;
    logic ctrl_reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    regfile_wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

    regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(8)) dut (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .bus          (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        pv;
        logic [4:0]  pr;
        logic [31:0] pd;
        logic        sv;
        logic [4:0]  sr;
        logic [31:0] sd;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        int          cnt;
        logic [31:0] mask;
        logic        rdy;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [4:0] pr, input logic [31:0] pd,
                         input logic sv, input logic [4:0] sr, input logic [31:0] sd);
        bus.pri_valid = pv;
        bus.pri_reg   = pr;
        bus.pri_data  = pd;
        bus.sec_valid = sv;
        bus.sec_reg   = sr;
        bus.sec_data  = sd;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string tag, input logic we, input logic [4:0] wr,
                             input logic [31:0] wd, input int cnt, input logic [31:0] mask,
                             input logic rdy, input logic stall);
        check({tag, ".we"}, 32'(bus.ctrl_writeEnable), 32'(we));
        if (we) begin
            check({tag, ".wreg"}, 32'(bus.ctrl_writeReg), 32'(wr));
            check({tag, ".wdata"}, bus.data_writeReg, wd);
        end
        check({tag, ".count"}, 32'(bus.fifo_count), 32'(cnt));
        check({tag, ".mask"}, bus.pending_mask, mask);
        check({tag, ".ready"}, 32'(bus.sec_ready), 32'(rdy));
        check({tag, ".stall"}, 32'(bus.pri_stall), 32'(stall));
    endtask

    initial begin
        logic [4:0] got [5];
        int         n_got;

        //             pv  pr    pd            sv  sr    sd            we  wr    wd            cnt mask          rdy
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,     1'b1, 5'd5,  32'hDEADBEEF, 0, 32'h00000020, 1'b1};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,     1'b0, 5'd0,  32'h0,        0, 32'h00000000, 1'b1};
        vecs[2] = '{1'b1, 5'd0,  32'h11,       1'b0, 5'd0, 32'h0,     1'b0, 5'd0,  32'h0,        0, 32'h00000000, 1'b1};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'h22,    1'b0, 5'd0,  32'h0,        0, 32'h00000000, 1'b1};
        vecs[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3, 32'h33,    1'b0, 5'd0,  32'h0,        1, 32'h00000008, 1'b1};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,     1'b1, 5'd3,  32'h33,       0, 32'h00000008, 1'b1};
        vecs[6] = '{1'b1, 5'd7,  32'h77,       1'b1, 5'd8, 32'h88,    1'b1, 5'd7,  32'h77,       1, 32'h00000180, 1'b1};
        vecs[7] = '{1'b1, 5'd10, 32'hAA,       1'b0, 5'd0, 32'h0,     1'b1, 5'd10, 32'hAA,       1, 32'h00000500, 1'b1};
        vecs[8] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,     1'b1, 5'd8,  32'h88,       0, 32'h00000100, 1'b1};
        vecs[9] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,     1'b0, 5'd0,  32'h0,        0, 32'h00000000, 1'b1};

        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        ctrl_reset_n = 1'b0;
        #2;
        check("reset.we", 32'(bus.ctrl_writeEnable), 32'd0);
        check("reset.wreg", 32'(bus.ctrl_writeReg), 32'd0);
        check("reset.wdata", bus.data_writeReg, 32'd0);
        check("reset.count", 32'(bus.fifo_count), 32'd0);
        check("reset.ready", 32'(bus.sec_ready), 32'd1);
        check("reset.stall", 32'(bus.pri_stall), 32'd0);
        check("reset.mask", bus.pending_mask, 32'd0);
        tick();
        ctrl_reset_n = 1'b1;

        // Single-cycle behaviour: primary latency, r0 drop, sec latency, priority.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].pv, vecs[i].pr, vecs[i].pd, vecs[i].sv, vecs[i].sr, vecs[i].sd);
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].we, vecs[i].wr, vecs[i].wd,
                      vecs[i].cnt, vecs[i].mask, vecs[i].rdy, 1'b0);
        end

        // Fill under continuous primary traffic, then drain while a push waits.
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h102); tick();
        check_out("fill1", 1'b1, 5'd1, 32'h11, 1, 32'h00000006, 1'b1, 1'b0);
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd3, 32'h103); tick();
        check_out("fill2", 1'b1, 5'd1, 32'h11, 2, 32'h0000000E, 1'b1, 1'b0);
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd4, 32'h104); tick();
        check_out("fill3", 1'b1, 5'd1, 32'h11, 3, 32'h0000001E, 1'b1, 1'b0);
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd5, 32'h105); tick();
        check_out("fill4", 1'b1, 5'd1, 32'h11, 4, 32'h0000003E, 1'b0, 1'b0);
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd6, 32'h106); tick();
        check_out("full_hold", 1'b1, 5'd1, 32'h11, 4, 32'h0000003E, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h106); tick();
        check_out("drain_no_accept", 1'b1, 5'd2, 32'h102, 3, 32'h0000003C, 1'b1, 1'b0);
        got[0] = bus.ctrl_writeReg;
        tick();
        check_out("push_pop", 1'b1, 5'd3, 32'h103, 3, 32'h00000078, 1'b1, 1'b0);
        got[1] = bus.ctrl_writeReg;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0); tick();
        check_out("drain_r4", 1'b1, 5'd4, 32'h104, 2, 32'h00000070, 1'b1, 1'b0);
        got[2] = bus.ctrl_writeReg;
        tick();
        check_out("drain_r5", 1'b1, 5'd5, 32'h105, 1, 32'h00000060, 1'b1, 1'b0);
        got[3] = bus.ctrl_writeReg;
        tick();
        check_out("drain_r6", 1'b1, 5'd6, 32'h106, 0, 32'h00000040, 1'b1, 1'b0);
        got[4] = bus.ctrl_writeReg;
        n_got = 5;
        for (int k = 0; k < n_got; k++)
            check($sformatf("order%0d", k), 32'(got[k]), 32'(k + 2));
        tick();
        check_out("drain_idle", 1'b0, 5'd0, 32'h0, 0, 32'h00000000, 1'b1, 1'b0);

        // Starvation: r9 waits behind 8 primary wins, then takes the stall slot.
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h1234); tick();
        check_out("starve_enq", 1'b1, 5'd1, 32'h11, 1, 32'h00000202, 1'b1, 1'b0);
        drive(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("starve_lost%0d.stall", k), 32'(bus.pri_stall), 32'(k == 8));
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0); tick();
        check_out("starve_win", 1'b1, 5'd9, 32'h1234, 0, 32'h00000200, 1'b1, 1'b0);
        drive(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'h0); tick();
        check_out("starve_after", 1'b1, 5'd1, 32'h11, 0, 32'h00000002, 1'b1, 1'b0);

        // Reset with three entries queued behind primary traffic.
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd11, 32'h111); tick();
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd12, 32'h112); tick();
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd13, 32'h113); tick();
        check("pre_reset.count", 32'(bus.fifo_count), 32'd3);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #2;
        ctrl_reset_n = 1'b0;
        #1;
        check_out("mid_reset", 1'b0, 5'd0, 32'h0, 0, 32'h00000000, 1'b1, 1'b0);
        tick();
        ctrl_reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_out($sformatf("post_reset%0d", k), 1'b0, 5'd0, 32'h0, 0, 32'h00000000, 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
